// File: rtl/cache_assoc.sv
// N-way set-associative write-back, write-allocate cache with round-robin replacement.
// A single FSM sequences lookup, multi-word write-back and multi-word refill.
module cache_assoc #(
    parameter int unsigned SET_WIDTH    = 2,
    parameter int unsigned OFFSET_WIDTH = 4,
    parameter int unsigned WAYS         = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned TAG_WIDTH = 32 - SET_WIDTH - OFFSET_WIDTH;
    localparam int unsigned WORD_W    = OFFSET_WIDTH - 2;
    localparam int unsigned WORDS     = 1 << WORD_W;
    localparam int unsigned SETS      = 1 << SET_WIDTH;
    localparam int unsigned WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL} state_e;

    state_e               state_q, state_d;
    logic                 ready_q;
    logic [WORD_W-1:0]    word_q, word_d;
    logic [31:0]          addr_q;
    logic                 we_q;
    logic [31:0]          wdata_q;
    logic [3:0]           be_q;
    logic [WAY_W-1:0]     victim_q;
    logic                 from_ptr_q;

    logic                 valid_q [SETS][WAYS];
    logic                 dirty_q [SETS][WAYS];
    logic [TAG_WIDTH-1:0] tag_q   [SETS][WAYS];
    logic [31:0]          data_q  [SETS][WAYS][WORDS];
    logic [WAY_W-1:0]     ptr_q   [SETS];

    logic [TAG_WIDTH-1:0] req_tag;
    logic [SET_WIDTH-1:0] req_idx;
    logic [WORD_W-1:0]    req_word;
    logic                 hit, inv_found, vict_dirty, last_word;
    logic [WAY_W-1:0]     hit_way, inv_way, vict_way;
    logic                 accept, wr_hit, miss, wb_done, rf_wr, rf_done;
    logic                 unused_addr_lsb;

    assign unused_addr_lsb = ^{req_addr_i[1:0], addr_q[1:0]};

    assign req_tag   = addr_q[31 -: TAG_WIDTH];
    assign req_idx   = addr_q[OFFSET_WIDTH +: SET_WIDTH];
    assign req_word  = addr_q[2 +: WORD_W];
    assign last_word = (word_q == WORD_W'(WORDS - 1));
    assign req_ready_o = ready_q;

    // Tag match and victim choice (lowest invalid way, else the set's pointer)
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!valid_q[req_idx][WAYS-1-i]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(WAYS - 1 - i);
            end
        end
        vict_way   = inv_found ? inv_way : ptr_q[req_idx];
        vict_dirty = valid_q[req_idx][vict_way] && dirty_q[req_idx][vict_way];
    end

    // Next-state and output decode; all outputs derive from registered state only
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        resp_valid_o = 1'b0;
        resp_rdata_o = '0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        accept       = 1'b0;
        wr_hit       = 1'b0;
        miss         = 1'b0;
        wb_done      = 1'b0;
        rf_wr        = 1'b0;
        rf_done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i && ready_q) begin
                    accept  = 1'b1;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    resp_valid_o = 1'b1;
                    if (we_q) wr_hit = 1'b1;
                    else      resp_rdata_o = data_q[req_idx][hit_way][req_word];
                    state_d = S_IDLE;
                end else begin
                    miss    = 1'b1;
                    word_d  = '0;
                    state_d = vict_dirty ? S_WRITEBACK : S_REFILL;
                end
            end
            S_WRITEBACK: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {tag_q[req_idx][victim_q], req_idx, word_q, 2'b00};
                mem_wdata_o = data_q[req_idx][victim_q][word_q];
                if (mem_ack_i) begin
                    word_d = word_q + WORD_W'(1);
                    if (last_word) begin
                        wb_done = 1'b1;
                        state_d = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {req_tag, req_idx, word_q, 2'b00};
                if (mem_ack_i) begin
                    rf_wr  = 1'b1;
                    word_d = word_q + WORD_W'(1);
                    if (last_word) begin
                        rf_done = 1'b1;
                        state_d = S_LOOKUP;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            word_q     <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            victim_q   <= '0;
            from_ptr_q <= 1'b0;
            for (int unsigned s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                end
            end
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == S_IDLE);
            word_q  <= word_d;
            if (accept) begin
                addr_q  <= req_addr_i;
                we_q    <= req_we_i;
                wdata_q <= req_wdata_i;
                be_q    <= req_be_i;
            end
            if (miss) begin
                victim_q   <= vict_way;
                from_ptr_q <= !inv_found;
            end
            if (wr_hit)  dirty_q[req_idx][hit_way]  <= 1'b1;
            if (wb_done) dirty_q[req_idx][victim_q] <= 1'b0;
            if (rf_done) begin
                valid_q[req_idx][victim_q] <= 1'b1;
                dirty_q[req_idx][victim_q] <= 1'b0;
                if (from_ptr_q) begin
                    ptr_q[req_idx] <= (ptr_q[req_idx] == WAY_W'(WAYS - 1)) ? '0
                                      : ptr_q[req_idx] + WAY_W'(1);
                end
            end
        end
    end

    // Tag and data storage carry no reset; valid bits qualify them
    always_ff @(posedge clk_i) begin
        if (rf_done) tag_q[req_idx][victim_q] <= req_tag;
        if (rf_wr)   data_q[req_idx][victim_q][word_q] <= mem_rdata_i;
        if (wr_hit) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_q[b]) data_q[req_idx][hit_way][req_word][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

endmodule

// File: doc/cache_assoc.md
Name: cache_assoc

Overview:
- Parametrised successor to the single-cycle write-back cache: N-way set-associative, write-back, write-allocate.
- Per-set round-robin replacement, per-byte write enables.
- Sits between the CPU pipeline and the memory bus. CPU side uses a valid/ready request and a one-cycle response pulse. Memory side uses a word-wide req/ack handshake with variable latency.
- Line refill and write-back are multi-word sequences driven by an internal FSM.

Parameters:
- SET_WIDTH, 2, set index bits; number of sets = 2**SET_WIDTH; must be >= 1.
- OFFSET_WIDTH, 4, block offset bits; words per line WORDS = 2**(OFFSET_WIDTH-2); must be >= 3.
- WAYS, 2, lines per set; power of two, >= 1 (1 = direct mapped).
- TAG_WIDTH, 32-SET_WIDTH-OFFSET_WIDTH, tag bits; derived, not overridable.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- req_valid_i  input  1  CPU request valid.
- req_ready_o  output  1  cache can accept a request.
- req_we_i  input  1  1 = write, 0 = read.
- req_addr_i  input  32  byte address; bits [1:0] ignored.
- req_wdata_i  input  32  write data.
- req_be_i  input  4  byte enables for writes; ignored for reads.
- resp_valid_o  output  1  one-cycle completion pulse (reads and writes).
- resp_rdata_o  output  32  read data; valid only with resp_valid_o on a read, 0 otherwise.
- mem_req_o  output  1  memory word transfer request.
- mem_we_o  output  1  1 = memory write.
- mem_addr_o  output  32  word-aligned memory address.
- mem_wdata_o  output  32  memory write data.
- mem_ack_i  input  1  transfer complete; read data valid this cycle.
- mem_rdata_i  input  32  memory read data.

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE; all valid/dirty bits and victim pointers cleared.
  - All outputs 0, including req_ready_o.
  - Reset mid-operation abandons the transfer: mem_req_o drops immediately and dirty data is lost.
- Storage: flop arrays valid[set][way], dirty[set][way], tag[set][way], data[set][way][word].
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&req_ready_o, latch addr/we/wdata/be and go to LOOKUP.
- LOOKUP:
  - req_ready_o=0. Compare latched tag against all valid ways of the set; at most one way may match.
  - Hit, read: resp_valid_o=1 this cycle with the word; go to IDLE.
  - Hit, write: merge bytes where be=1, set dirty; resp_valid_o=1 this cycle; go to IDLE.
  - Miss: choose the victim. The lowest-numbered invalid way wins; if none is invalid, use the set's victim pointer.
  - Miss with victim valid&dirty: go to WRITEBACK. Otherwise go to REFILL.
- WRITEBACK:
  - Words 0..WORDS-1 in order, one memory write each.
  - mem_addr_o={victim_tag,index,word,2'b00}; mem_we_o=1; mem_wdata_o=victim word.
  - After the ack of the last word, clear dirty and go to REFILL.
- REFILL:
  - Words 0..WORDS-1, memory reads; mem_addr_o={req_tag,index,word,2'b00}; mem_we_o=0.
  - On each ack, write mem_rdata_i into the victim way.
  - After the last ack: set valid=1, tag=req_tag, dirty=0.
  - Advance the set's victim pointer modulo WAYS, only if the victim came from the pointer.
  - Return to LOOKUP, which then hits. Write misses are therefore allocated and merged there.
- Memory handshake:
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are held stable until the cycle mem_ack_i=1.
  - Ack may arrive in the first request cycle (zero wait).
  - The next word's request may follow in the very next cycle; mem_req_o may stay high across words.
  - mem_ack_i while mem_req_o=0 is ignored.
- Latency, counted from the acceptance edge:
  - Hit: resp_valid_o in the next cycle.
  - Clean miss: 1 + WORDS*(1+wait) + 1 cycles.
  - Dirty miss: adds WORDS*(1+wait).
- No response back-pressure: the requester must consume the resp_valid_o pulse. Only one request is outstanding at a time.

Test Plan:
- Cold read: reset, read 0x040; memory returns addr^0xA5A5A5A5 with 2 wait cycles → reads from 0x040, 0x044, 0x048, 0x04C in order; resp_rdata_o=0xA5A5A5E5; mem_we_o=0 throughout.
- Hit: read 0x048 → resp_valid_o the cycle after acceptance, data 0xA5A5A5ED, mem_req_o stays 0.
- Partial write: write 0x044 with wdata 0x12345678, be=4'b0011, then read 0x044 → 0xA5A55678; no memory traffic.
- Eviction: read 0x140 (fills way1), then read 0x240 (same set 0, evicts dirty way0) → four writes to 0x040..0x04C (0x044 carries 0xA5A55678), then four reads 0x240..0x24C; next read 0x040 evicts way1 (clean: reads only).
- Zero-wait memory: ack in the same cycle as each request → clean miss completes in WORDS+2 cycles with mem_req_o continuously high.
- Reset mid-refill: drop rst_ni after the 2nd refill ack → all outputs 0 immediately; after release, read 0x040 misses again with a full 4-word refill.
